// File: rtl/multicycle.sv
// ----------------------------------------------------------------------------
// multicycle - multicycle RV32I core top
//
// Each instruction walks FETCH -> EXEC -> [MEM] -> WB. FETCH and MEM each last
// 1+MEM_WAIT cycles; EXEC and WB last one cycle. An unknown opcode sends the
// core to HALT, which only reset leaves.
//
// Instruction memory is a ROM of IMEM_WORDS words whose contents come from
// IMEM_INIT (word i at bits [32*i +: 32]). Words past IMEM_WORDS read as 0,
// which is an illegal opcode.
//
// LSU map (offsets within the DMEM_AW-bit address):
//   top bit set      : data RAM
//   top bit clear    : IO, decoded on addr[7:2]
//     0x000 LEDR, 0x010 LEDG, 0x020..0x03C HEX0..HEX7, 0x040 LCD, 0x080 SW (read)
//
// Optional feature macro: INSTRET_CNT_EN (retired-instruction counter on instret_o).
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   io_sw_i                switch inputs (readable at 0x080)
//   io_lcd_o, io_ledg_o,
//   io_ledr_o, io_hex*_o   IO output registers written by stores
//   pc_o                   PC of the instruction in flight
//   retire_o               one-cycle pulse in WB
//   halt_o                 sticky illegal-opcode halt
//   instret_o              retired-instruction count (0 when the counter is not built)
// ----------------------------------------------------------------------------
module multicycle #(
    parameter logic [31:0]              RESET_PC   = 32'h0000_0000,
    parameter int unsigned              IMEM_AW    = 14,
    parameter int unsigned              DMEM_AW    = 12,
    parameter int unsigned              MEM_WAIT   = 0,
    parameter int unsigned              IMEM_WORDS = 128,
    parameter logic [IMEM_WORDS*32-1:0] IMEM_INIT  = '0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] io_sw_i,
    output logic [31:0] io_lcd_o,
    output logic [31:0] io_ledg_o,
    output logic [31:0] io_ledr_o,
    output logic [31:0] io_hex0_o,
    output logic [31:0] io_hex1_o,
    output logic [31:0] io_hex2_o,
    output logic [31:0] io_hex3_o,
    output logic [31:0] io_hex4_o,
    output logic [31:0] io_hex5_o,
    output logic [31:0] io_hex6_o,
    output logic [31:0] io_hex7_o,
    output logic [31:0] pc_o,
    output logic        retire_o,
    output logic        halt_o,
    output logic [31:0] instret_o
);
    localparam logic [3:0] WaitLast = 4'(MEM_WAIT);
    localparam logic [6:0] OpLui = 7'b0110111, OpAuipc = 7'b0010111, OpJal = 7'b1101111,
                           OpJalr = 7'b1100111, OpBr = 7'b1100011, OpLd = 7'b0000011,
                           OpSt = 7'b0100011, OpImm = 7'b0010011, OpReg = 7'b0110011;

    typedef enum logic [2:0] {StFetch, StExec, StMem, StWb, StHalt} state_t;
    typedef enum logic [1:0] {WbAlu, WbPc4, WbLd} wb_sel_t;

    state_t      r_state, w_state_d;
    logic [3:0]  r_wait, w_wait_d;
    logic [31:0] r_pc, r_ir, r_alu_q, r_pc4_q, r_ld_q;
    logic        r_br_taken;
    logic [31:0] r_rf [32];
    logic [31:0] r_ram [2**(DMEM_AW-3)];
    logic [31:0] r_ledr, r_ledg, r_lcd;
    logic [31:0] r_hex [8];

    function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] wdat,
                                            input logic [3:0] be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) res[8*b +: 8] = be[b] ? wdat[8*b +: 8] : old[8*b +: 8];
        return res;
    endfunction

    // ---------------- fetch ----------------
    logic        w_last;
    logic [31:0] w_imem_word, w_inst;
    assign w_last      = (r_wait == WaitLast);
    assign w_imem_word = 32'(r_pc[IMEM_AW-1:2]);
    always_comb begin
        w_inst = '0;
        if (w_imem_word < IMEM_WORDS) w_inst = IMEM_INIT[w_imem_word*32 +: 32];
    end

    // ---------------- decode ----------------
    logic [6:0]  w_opc;
    logic [4:0]  w_rd, w_rs1a, w_rs2a;
    logic [2:0]  w_f3;
    logic [31:0] w_rs1, w_rs2, w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    assign w_opc   = r_ir[6:0];
    assign w_rd    = r_ir[11:7];
    assign w_f3    = r_ir[14:12];
    assign w_rs1a  = r_ir[19:15];
    assign w_rs2a  = r_ir[24:20];
    assign w_rs1   = r_rf[w_rs1a];
    assign w_rs2   = r_rf[w_rs2a];
    assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_imm_u = {r_ir[31:12], 12'b0};
    assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

    logic        w_legal, w_rf_we, w_jump, w_branch, w_is_ld, w_is_st, w_alt;
    logic [2:0]  w_alu_f3;
    logic [31:0] w_opa, w_opb;
    wb_sel_t     w_wb_sel;
    always_comb begin
        w_legal = 1'b1; w_rf_we = 1'b0; w_jump = 1'b0; w_branch = 1'b0;
        w_is_ld = 1'b0; w_is_st = 1'b0; w_alt = 1'b0; w_alu_f3 = 3'b000;
        w_opa = w_rs1; w_opb = w_imm_i; w_wb_sel = WbAlu;
        unique case (w_opc)
            OpLui:   begin w_opa = '0;   w_opb = w_imm_u; w_rf_we = 1'b1; end
            OpAuipc: begin w_opa = r_pc; w_opb = w_imm_u; w_rf_we = 1'b1; end
            OpJal:   begin
                w_opa = r_pc; w_opb = w_imm_j; w_rf_we = 1'b1; w_wb_sel = WbPc4; w_jump = 1'b1;
            end
            OpJalr:  begin w_rf_we = 1'b1; w_wb_sel = WbPc4; w_jump = 1'b1; end
            OpBr:    begin w_opa = r_pc; w_opb = w_imm_b; w_branch = 1'b1; end
            OpLd:    begin w_rf_we = 1'b1; w_wb_sel = WbLd; w_is_ld = 1'b1; end
            OpSt:    begin w_opb = w_imm_s; w_is_st = 1'b1; end
            OpImm:   begin
                w_rf_we = 1'b1; w_alu_f3 = w_f3;
                w_alt = (w_f3 == 3'b101) && r_ir[30];  // only SRAI uses the alt bit
            end
            OpReg:   begin w_rf_we = 1'b1; w_alu_f3 = w_f3; w_opb = w_rs2; w_alt = r_ir[30]; end
            default: w_legal = 1'b0;
        endcase
    end

    // ---------------- ALU / branch compare ----------------
    logic [31:0] w_alu;
    logic        w_cmp;
    always_comb begin
        unique case (w_alu_f3)
            3'b000:  w_alu = w_alt ? w_opa - w_opb : w_opa + w_opb;
            3'b001:  w_alu = w_opa << w_opb[4:0];
            3'b010:  w_alu = {31'b0, $signed(w_opa) < $signed(w_opb)};
            3'b011:  w_alu = {31'b0, w_opa < w_opb};
            3'b100:  w_alu = w_opa ^ w_opb;
            3'b101:  w_alu = w_alt ? $unsigned($signed(w_opa) >>> w_opb[4:0]) : w_opa >> w_opb[4:0];
            3'b110:  w_alu = w_opa | w_opb;
            default: w_alu = w_opa & w_opb;
        endcase
        unique case (w_f3)
            3'b000:  w_cmp = (w_rs1 == w_rs2);
            3'b001:  w_cmp = (w_rs1 != w_rs2);
            3'b100:  w_cmp = $signed(w_rs1) < $signed(w_rs2);
            3'b101:  w_cmp = $signed(w_rs1) >= $signed(w_rs2);
            3'b110:  w_cmp = w_rs1 < w_rs2;
            3'b111:  w_cmp = w_rs1 >= w_rs2;
            default: w_cmp = 1'b0;
        endcase
    end

    // ---------------- LSU ----------------
    logic [DMEM_AW-1:0] w_addr;
    logic [1:0]         w_off;
    logic               w_ram_sel, w_mem_wren;
    logic [5:0]         w_io_idx;
    logic [31:0]        w_rdata, w_rshift, w_ld_fmt, w_sdata;
    logic [3:0]         w_be;
    assign w_addr     = r_alu_q[DMEM_AW-1:0];
    assign w_off      = w_addr[1:0];
    assign w_ram_sel  = w_addr[DMEM_AW-1];
    assign w_io_idx   = w_addr[7:2];
    // One write per store: the strobe exists only on the final MEM cycle.
    assign w_mem_wren = (r_state == StMem) && w_last && w_is_st;
    assign w_sdata    = w_rs2 << {w_off, 3'b000};
    assign w_be       = (w_f3[1:0] == 2'b00) ? 4'b0001 << w_off :
                        (w_f3[1:0] == 2'b01) ? 4'b0011 << w_off : 4'b1111;
    always_comb begin
        w_rdata = '0;
        if (w_ram_sel) w_rdata = r_ram[w_addr[DMEM_AW-2:2]];
        else if (w_io_idx[5:3] == 3'b001) w_rdata = r_hex[w_io_idx[2:0]];
        else if (w_io_idx == 6'd0)  w_rdata = r_ledr;
        else if (w_io_idx == 6'd4)  w_rdata = r_ledg;
        else if (w_io_idx == 6'd16) w_rdata = r_lcd;
        else if (w_io_idx == 6'd32) w_rdata = io_sw_i;
        w_rshift = w_rdata >> {w_off, 3'b000};
        unique case (w_f3)
            3'b000:  w_ld_fmt = {{24{w_rshift[7]}}, w_rshift[7:0]};
            3'b001:  w_ld_fmt = {{16{w_rshift[15]}}, w_rshift[15:0]};
            3'b100:  w_ld_fmt = {24'b0, w_rshift[7:0]};
            3'b101:  w_ld_fmt = {16'b0, w_rshift[15:0]};
            default: w_ld_fmt = w_rshift;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_mem_wren && w_ram_sel)
            r_ram[w_addr[DMEM_AW-2:2]] <= f_merge(r_ram[w_addr[DMEM_AW-2:2]], w_sdata, w_be);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ledr <= '0; r_ledg <= '0; r_lcd <= '0;
            for (int i = 0; i < 8; i++) r_hex[i] <= '0;
        end else if (w_mem_wren && !w_ram_sel) begin
            if (w_io_idx[5:3] == 3'b001)
                r_hex[w_io_idx[2:0]] <= f_merge(r_hex[w_io_idx[2:0]], w_sdata, w_be);
            else if (w_io_idx == 6'd0)  r_ledr <= f_merge(r_ledr, w_sdata, w_be);
            else if (w_io_idx == 6'd4)  r_ledg <= f_merge(r_ledg, w_sdata, w_be);
            else if (w_io_idx == 6'd16) r_lcd  <= f_merge(r_lcd, w_sdata, w_be);
        end
    end

    // ---------------- FSM ----------------
    always_comb begin
        w_state_d = r_state;
        w_wait_d  = r_wait;
        unique case (r_state)
            StFetch, StMem: begin
                if (w_last) begin
                    w_wait_d  = '0;
                    w_state_d = (r_state == StFetch) ? StExec : StWb;
                end else begin
                    w_wait_d = r_wait + 4'd1;
                end
            end
            StExec:  w_state_d = !w_legal ? StHalt : (w_is_ld || w_is_st) ? StMem : StWb;
            StWb:    w_state_d = StFetch;
            default: w_state_d = StHalt;
        endcase
    end

    logic [31:0] w_wb_data;
    assign w_wb_data = (w_wb_sel == WbPc4) ? r_pc4_q : (w_wb_sel == WbLd) ? r_ld_q : r_alu_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StFetch; r_wait <= '0; r_pc <= RESET_PC; r_ir <= 32'h0000_0013;
            r_alu_q <= '0; r_pc4_q <= '0; r_ld_q <= '0; r_br_taken <= 1'b0;
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else begin
            r_state <= w_state_d;
            r_wait  <= w_wait_d;
            if (r_state == StFetch && w_last) r_ir <= w_inst;
            if (r_state == StExec && w_legal) begin
                r_alu_q    <= w_alu;
                r_br_taken <= w_jump || (w_branch && w_cmp);
                r_pc4_q    <= r_pc + 32'd4;
            end
            if (r_state == StMem && w_last && w_is_ld) r_ld_q <= w_ld_fmt;
            if (r_state == StWb) begin
                r_pc <= r_br_taken ? {r_alu_q[31:1], 1'b0} : r_pc4_q;
                if (w_rf_we && w_rd != 5'd0) r_rf[w_rd] <= w_wb_data;
            end
        end
    end

    assign pc_o      = r_pc;
    assign retire_o  = (r_state == StWb);
    assign halt_o    = (r_state == StHalt);
    assign io_ledr_o = r_ledr;
    assign io_ledg_o = r_ledg;
    assign io_lcd_o  = r_lcd;
    assign io_hex0_o = r_hex[0];
    assign io_hex1_o = r_hex[1];
    assign io_hex2_o = r_hex[2];
    assign io_hex3_o = r_hex[3];
    assign io_hex4_o = r_hex[4];
    assign io_hex5_o = r_hex[5];
    assign io_hex6_o = r_hex[6];
    assign io_hex7_o = r_hex[7];

`ifdef INSTRET_CNT_EN
    logic [31:0] r_instret;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       r_instret <= '0;
        else if (retire_o) r_instret <= r_instret + 32'd1;
    end
    assign instret_o = r_instret;
`else
    assign instret_o = 32'h0;
`endif
endmodule

// File: tb/tb_multicycle.sv
// ----------------------------------------------------------------------------
// tb_multicycle - directed bench for the multicycle core (MEM_WAIT = 2, so a
// non-memory instruction takes 5 cycles and a load/store takes 8).
// ----------------------------------------------------------------------------
module tb_multicycle;
    localparam int unsigned NW = 96;

    function automatic logic [NW*32-1:0] build_prog();
        logic [NW*32-1:0] p;
        p = '0;
        p[0*32 +: 32]  = 32'h00500093; // 0x000 addi x1,x0,5
        p[1*32 +: 32]  = 32'h00708113; // 0x004 addi x2,x1,7
        p[2*32 +: 32]  = 32'h000071B7; // 0x008 lui  x3,0x7
        p[3*32 +: 32]  = 32'h0021A023; // 0x00C sw   x2,0(x3)      LEDR
        p[4*32 +: 32]  = 32'h00108463; // 0x010 beq  x1,x1,+8
        p[5*32 +: 32]  = 32'h00100493; // 0x014 addi x9,x0,1 (skipped)
        p[6*32 +: 32]  = 32'h00109463; // 0x018 bne  x1,x1,+8
        p[7*32 +: 32]  = 32'h10300313; // 0x01C addi x6,x0,0x103
        p[8*32 +: 32]  = 32'h000302E7; // 0x020 jalr x5,0(x6) -> 0x102
        p[64*32 +: 32] = 32'h0051A823; // 0x102 sw   x5,0x10(x3)   LEDG
        p[65*32 +: 32] = 32'h0001A383; // 0x106 lw   x7,0(x3)
        p[66*32 +: 32] = 32'h00138393; // 0x10A addi x7,x7,1
        p[67*32 +: 32] = 32'h0271A023; // 0x10E sw   x7,0x20(x3)   HEX0
        p[68*32 +: 32] = 32'h0801A403; // 0x112 lw   x8,0x80(x3)   SW
        p[69*32 +: 32] = 32'h0481A023; // 0x116 sw   x8,0x40(x3)   LCD
        p[70*32 +: 32] = 32'hFFF00513; // 0x11A addi x10,x0,-1
        p[71*32 +: 32] = 32'hFEA18FA3; // 0x11E sb   x10,-1(x3)    RAM
        p[72*32 +: 32] = 32'hFFF18603; // 0x122 lb   x12,-1(x3)
        p[73*32 +: 32] = 32'hFFF1C683; // 0x126 lbu  x13,-1(x3)
        p[74*32 +: 32] = 32'h02D1A223; // 0x12A sw   x13,0x24(x3)  HEX1
        p[75*32 +: 32] = 32'h02C1A423; // 0x12E sw   x12,0x28(x3)  HEX2
        p[76*32 +: 32] = 32'h40110733; // 0x132 sub  x14,x2,x1
        p[77*32 +: 32] = 32'h001557B3; // 0x136 srl  x15,x10,x1
        p[78*32 +: 32] = 32'h02E1A623; // 0x13A sw   x14,0x2C(x3)  HEX3
        p[79*32 +: 32] = 32'h02F1A823; // 0x13E sw   x15,0x30(x3)  HEX4
        p[80*32 +: 32] = 32'h00001817; // 0x142 auipc x16,1
        p[81*32 +: 32] = 32'h0301AA23; // 0x146 sw   x16,0x34(x3)  HEX5
        p[82*32 +: 32] = 32'hFFFFFFFF; // 0x14A illegal
        return p;
    endfunction
    localparam logic [NW*32-1:0] PROG = build_prog();

    logic        clk, rst_n;
    logic [31:0] sw;
    logic [31:0] lcd, ledg, ledr, hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [31:0] pc, instret;
    logic        retire, halt;

    multicycle #(
        .RESET_PC   (32'h0),
        .IMEM_AW    (14),
        .DMEM_AW    (12),
        .MEM_WAIT   (2),
        .IMEM_WORDS (NW),
        .IMEM_INIT  (PROG)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .io_sw_i   (sw),
        .io_lcd_o  (lcd),
        .io_ledg_o (ledg),
        .io_ledr_o (ledr),
        .io_hex0_o (hex0),
        .io_hex1_o (hex1),
        .io_hex2_o (hex2),
        .io_hex3_o (hex3),
        .io_hex4_o (hex4),
        .io_hex5_o (hex5),
        .io_hex6_o (hex6),
        .io_hex7_o (hex7),
        .pc_o      (pc),
        .retire_o  (retire),
        .halt_o    (halt),
        .instret_o (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int edges;
    bit mon_en  = 1'b0;
    logic [31:0] ret_pc [$];
    int          ret_cyc [$];

    always @(posedge clk or negedge rst_n)
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;

    // Cycle numbering: cycle k is the k-th clock period after reset release.
    always @(negedge clk)
        if (mon_en && rst_n && retire) begin
            ret_pc.push_back(pc);
            ret_cyc.push_back(edges + 1);
        end

    logic [31:0] exp_pc [26] = '{
        32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h018, 32'h01C, 32'h020,
        32'h102, 32'h106, 32'h10A, 32'h10E, 32'h112, 32'h116, 32'h11A, 32'h11E,
        32'h122, 32'h126, 32'h12A, 32'h12E, 32'h132, 32'h136, 32'h13A, 32'h13E,
        32'h142, 32'h146};
    bit exp_mem [26] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0, 0, 1, 1,
                         0, 1};

    task automatic run_to(input int c);
        while (edges + 1 < c) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        n_tests++; if (pc !== 32'h0)   begin n_fail++; $display("FAIL reset_pc got %h want 0", pc); end
        n_tests++; if (retire !== 1'b0) begin n_fail++; $display("FAIL reset_retire got %b want 0", retire); end
        n_tests++; if (halt !== 1'b0)  begin n_fail++; $display("FAIL reset_halt got %b want 0", halt); end
        n_tests++; if (instret !== 32'h0) begin n_fail++; $display("FAIL reset_instret got %h want 0", instret); end
        n_tests++; if (ledr !== 32'h0 || hex0 !== 32'h0 || lcd !== 32'h0)
            begin n_fail++; $display("FAIL reset_io got ledr=%h hex0=%h lcd=%h want 0", ledr, hex0, lcd); end
    endtask

    task automatic test_alu_timing();
        run_to(4);
        n_tests++; if (retire !== 1'b0) begin n_fail++; $display("FAIL retire_in_exec got %b want 0", retire); end
        run_to(5);
        n_tests++; if (retire !== 1'b1 || pc !== 32'h0)
            begin n_fail++; $display("FAIL first_retire got retire=%b pc=%h want 1/0", retire, pc); end
        run_to(6);
        n_tests++; if (retire !== 1'b0) begin n_fail++; $display("FAIL retire_one_cycle got %b want 0", retire); end
        run_to(10);
        n_tests++; if (retire !== 1'b1 || pc !== 32'h4)
            begin n_fail++; $display("FAIL second_retire got retire=%b pc=%h want 1/4", retire, pc); end
    endtask

    task automatic test_store_timing();
        run_to(22);
        n_tests++; if (ledr !== 32'h0) begin n_fail++; $display("FAIL store_early got %h want 0", ledr); end
        run_to(23);
        n_tests++; if (ledr !== 32'd12 || retire !== 1'b1)
            begin n_fail++; $display("FAIL store_ledr got %h retire=%b want 0000000c/1", ledr, retire); end
    endtask

    task automatic test_program_flow();
        int c;
        c = 0;
        for (int i = 0; i < 200 && !halt; i++) @(negedge clk);
        n_tests++; if (halt !== 1'b1) begin n_fail++; $display("FAIL halt_reached got %b want 1", halt); end
        n_tests++; if (ret_pc.size() != 26)
            begin n_fail++; $display("FAIL retire_count got %0d want 26", ret_pc.size()); end
        for (int i = 0; i < 26 && i < ret_pc.size(); i++) begin
            c += exp_mem[i] ? 8 : 5;
            n_tests++; if (ret_pc[i] !== exp_pc[i] || ret_cyc[i] != c) begin
                n_fail++;
                $display("FAIL retire[%0d] got pc=%h cyc=%0d want pc=%h cyc=%0d",
                         i, ret_pc[i], ret_cyc[i], exp_pc[i], c);
            end
        end
    endtask

    task automatic test_io_results();
        n_tests++; if (ledg !== 32'h24)       begin n_fail++; $display("FAIL jalr_link got %h want 24", ledg); end
        n_tests++; if (hex0 !== 32'd13)       begin n_fail++; $display("FAIL load_io got %h want d", hex0); end
        n_tests++; if (lcd !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL load_sw got %h want a5a50f0f", lcd); end
        n_tests++; if (hex1 !== 32'hFF)       begin n_fail++; $display("FAIL lbu got %h want ff", hex1); end
        n_tests++; if (hex2 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL lb got %h want ffffffff", hex2); end
        n_tests++; if (hex3 !== 32'd7)        begin n_fail++; $display("FAIL sub got %h want 7", hex3); end
        n_tests++; if (hex4 !== 32'h07FF_FFFF) begin n_fail++; $display("FAIL srl got %h want 07ffffff", hex4); end
        n_tests++; if (hex5 !== 32'h1142)     begin n_fail++; $display("FAIL auipc got %h want 1142", hex5); end
        n_tests++; if (hex6 !== 32'h0 || hex7 !== 32'h0)
            begin n_fail++; $display("FAIL hex_untouched got %h %h want 0", hex6, hex7); end
    endtask

    task automatic test_halt();
        int n;
        n = ret_pc.size();
        repeat (20) @(negedge clk);
        n_tests++; if (halt !== 1'b1 || pc !== 32'h14A)
            begin n_fail++; $display("FAIL halt_hold got halt=%b pc=%h want 1/14a", halt, pc); end
        n_tests++; if (ret_pc.size() != n)
            begin n_fail++; $display("FAIL retire_in_halt got %0d want %0d", ret_pc.size(), n); end
    endtask

    task automatic test_instret();
        logic [31:0] exp;
`ifdef INSTRET_CNT_EN
        exp = 32'd26;
`else
        exp = 32'd0;
`endif
        n_tests++; if (instret !== exp) begin n_fail++; $display("FAIL instret got %h want %h", instret, exp); end
    endtask

    task automatic test_reset_clear();
        rst_n = 1'b0;
        #1;
        n_tests++; if (halt !== 1'b0 || pc !== 32'h0 || instret !== 32'h0 || ledr !== 32'h0)
            begin n_fail++; $display("FAIL reset_clear got halt=%b pc=%h instret=%h ledr=%h want 0", halt, pc, instret, ledr); end
    endtask

    task automatic test_reset_mid_mem();
        release_reset();
        run_to(21);
        rst_n = 1'b0;
        #1;
        n_tests++; if (pc !== 32'h0 || retire !== 1'b0)
            begin n_fail++; $display("FAIL midmem_reset got pc=%h retire=%b want 0/0", pc, retire); end
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (ledr !== 32'h0) begin n_fail++; $display("FAIL midmem_no_write got %h want 0", ledr); end
        rst_n = 1'b1;
        run_to(5);
        n_tests++; if (retire !== 1'b1 || pc !== 32'h0)
            begin n_fail++; $display("FAIL restart_retire got retire=%b pc=%h want 1/0", retire, pc); end
        run_to(23);
        n_tests++; if (ledr !== 32'd12) begin n_fail++; $display("FAIL restart_store got %h want c", ledr); end
    endtask

    initial begin
        rst_n = 1'b0;
        sw    = 32'hA5A5_0F0F;
        repeat (3) @(negedge clk);
        test_reset();
        mon_en = 1'b1;
        release_reset();
        test_alu_timing();
        test_store_timing();
        test_program_flow();
        test_io_results();
        test_halt();
        test_instret();
        mon_en = 1'b0;
        test_reset_clear();
        test_reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
